mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Memory controller that sits between the instruction cache / load-store buffer and the byte-wide unified RAM/IO bus.
- Serves instruction-cache line refills: 8 consecutive bytes are assembled into one 64-bit line and returned with a one-cycle done pulse.
- Also serves LSB loads and stores of 1, 2 or 4 bytes.
- Only block that drives the RAM address, data and write-enable pins.

Parameters:
- LINE_WIDTH, 64, bits per icache line (8 bytes per refill)
- ADDR_WIDTH, 32, address width on all ports
- IO_BASE, 32'h00030000, addresses at or above this are IO and are subject to io_buffer_full

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; asynchronous, active-low
- rdy_in  input  1  global ready; all state frozen when low
- if_signal  input  1  icache refill request, held until if_done
- if_addr  input  32  line base address (bits [2:0] = 0)
- if_done  output  1  one-cycle pulse: if_data valid
- if_data  output  64  line; byte at if_addr in [7:0], byte at if_addr+7 in [63:56]
- ls_signal  input  1  LSB request, held until ls_done
- ls_wr  input  1  1 = store, 0 = load
- ls_len  input  2  00 = byte, 01 = half, 10 = word; 11 is illegal
- ls_addr  input  32  access base address
- ls_wdata  input  32  store data, little-endian
- ls_done  output  1  one-cycle pulse: access complete, ls_rdata valid for loads
- ls_rdata  output  32  load data, zero-extended
- mem_din  input  8  RAM read byte
- mem_dout  output  8  RAM write byte
- mem_a  output  32  RAM byte address
- mem_wr  output  1  RAM write enable
- io_buffer_full  input  1  IO sink cannot accept a write this cycle

Behaviour:
- Reset (asynchronous, rst_in low): state IDLE; counters 0; all outputs 0 (if_done, ls_done, mem_wr, mem_a, mem_dout, if_data, ls_rdata).
- rdy_in low: no register changes; mem_wr output is gated combinationally (mem_wr = wr_q & rdy_in).
- States: IDLE, IFETCH, LOAD, STORE.
- IDLE accept rule, at a clock edge:
  - A request is accepted only if its done output is currently low. This prevents re-accepting a request that is still held high while its done pulse is being seen.
  - If ls_signal and if_signal are both eligible, ls wins.
  - Accept latches the address and length, drives mem_a <= base and clears the byte counter cnt <= 0.
- Byte count N: 8 for IFETCH; 1, 2 or 4 for LOAD and STORE.
- Reads (IFETCH, LOAD):
  - Edge E0 is the accept edge. mem_a <= base + i at edge E(i) for i = 0..N-1.
  - RAM has one cycle of read latency, so byte i is captured from mem_din at edge E(i+2).
  - At edge E(N+1): last byte captured, the done output is set to 1, state returns to IDLE, and the result register is updated in the same edge.
  - Done is cleared at the next edge.
  - Latency from accept edge to done visible: N+1 edges (IFETCH 9, word load 5).
- Store:
  - At edge E(i), i = 0..N-1: drive mem_a = base + i, mem_dout = ls_wdata[8i+7:8i], wr_q = 1.
  - IO stall: if the target address is >= IO_BASE and io_buffer_full is high at that edge, drive wr_q = 0, hold i and retry next edge.
  - The edge after the last byte is issued: wr_q <= 0, ls_done <= 1, state returns to IDLE.
- Data registers:
  - if_data and ls_rdata hold their value until the next completion of the same type.
  - Unused upper bytes of ls_rdata are 0.
- No address wrap handling beyond natural 32-bit modular increment.
- Requests changing while the controller is not in IDLE are ignored.
- Reset mid-operation aborts the transaction; no done pulse is produced.
- ls_len = 11 is treated as word.

Test Plan:
- RAM bytes 0x00..0x07 = 11..88; if_signal with if_addr = 0 -> if_done high exactly 9 edges after accept; if_data = 64'h8877665544332211; if_done is 1 cycle wide, and no second refill starts while if_signal is still high in the done cycle.
- Load word at 0x100 with RAM 0x100..0x103 = DE AD BE EF -> ls_rdata = 32'hEFBEADDE after 5 edges; half load -> 32'h0000ADDE; byte load -> 32'h000000DE.
- Store word 32'hA1B2C3D4 to 0x200 -> mem_wr high 4 consecutive cycles; mem_a = 0x200..0x203 with mem_dout D4, C3, B2, A1; ls_done the next cycle; readback returns the same word.
- Byte store to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for those 3 cycles, then one write of the byte, then ls_done.
- if_signal and ls_signal raised on the same edge -> the LS access completes first; the icache refill then starts the cycle after ls_done and still returns the correct line.
- rst_in pulsed low mid-IFETCH -> outputs 0 immediately and state IDLE; rdy_in held low for 4 cycles mid-store -> mem_wr low during the hold and the byte sequence resumes unchanged.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide RAM/IO bus controller serving icache line refills and LSB loads/stores.
// Reads pipeline one address per edge against a one-cycle-latency RAM; stores stall on a full IO sink.
module mem_ctrl #(
    parameter int LINE_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE = 32'h00030000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  if_signal,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [LINE_WIDTH-1:0] if_data,
    input  logic                  ls_signal,
    input  logic                  ls_wr,
    input  logic [1:0]            ls_len,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_done,
    output logic [31:0]           ls_rdata,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);
    typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;
    state_t state, state_d;
    logic [ADDR_WIDTH-1:0] base, st_addr;
    logic [31:0] wdata;
    logic [3:0] n, cnt, len_n;
    logic [4:0] rsh;
    logic [7:0] st_byte;
    logic wr_q, ls_go, if_go, stall;
    logic [LINE_WIDTH-9:0] line_q;
    logic [LINE_WIDTH-1:0] shifted;

    assign mem_wr = wr_q & rdy_in;

    always_comb begin
        ls_go = ls_signal && !ls_done;
        if_go = if_signal && !if_done;
        len_n = ls_len == 2'b00 ? 4'd1 : ls_len == 2'b01 ? 4'd2 : 4'd4;
        // in IDLE the store path previews byte 0 of the incoming request so it issues on the accept edge
        st_addr = state == STORE ? base + ADDR_WIDTH'(cnt) : ls_addr;
        st_byte = 8'((state == STORE ? wdata : ls_wdata) >> {(state == STORE ? cnt[1:0] : 2'd0), 3'd0});
        stall = st_addr >= IO_BASE && io_buffer_full;
        shifted = {mem_din, line_q};
        rsh = n == 4'd1 ? 5'd24 : n == 4'd2 ? 5'd16 : 5'd0;
        state_d = state;
        if (state == IDLE)
            state_d = ls_go ? (ls_wr ? STORE : LOAD) : if_go ? IFETCH : IDLE;
        else if (cnt == n)
            state_d = IDLE;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state    <= IDLE;
            base     <= '0;
            wdata    <= '0;
            n        <= '0;
            cnt      <= '0;
            wr_q     <= 1'b0;
            line_q   <= '0;
            mem_a    <= '0;
            mem_dout <= '0;
            if_done  <= 1'b0;
            ls_done  <= 1'b0;
            if_data  <= '0;
            ls_rdata <= '0;
        end else if (rdy_in) begin
            state   <= state_d;
            if_done <= 1'b0;
            ls_done <= 1'b0;
            case (state)
                IDLE:
                    if (ls_go) begin
                        base  <= ls_addr;
                        n     <= len_n;
                        wdata <= ls_wdata;
                        mem_a <= ls_addr;
                        cnt   <= ls_wr && !stall ? 4'd1 : 4'd0;
                        if (ls_wr) begin
                            mem_dout <= st_byte;
                            wr_q     <= !stall;
                        end
                    end else if (if_go) begin
                        base  <= if_addr;
                        n     <= 4'd8;
                        mem_a <= if_addr;
                        cnt   <= 4'd0;
                    end
                IFETCH, LOAD: begin
                    // cnt == k-1 at edge E(k): byte k-2 arrives on mem_din, address k goes out
                    cnt <= cnt + 4'd1;
                    if (cnt != 4'd0) line_q <= shifted[LINE_WIDTH-1:8];
                    if (cnt + 4'd1 < n) mem_a <= base + ADDR_WIDTH'(cnt + 4'd1);
                    if (cnt == n) begin
                        if (state == IFETCH) begin
                            if_data <= shifted;
                            if_done <= 1'b1;
                        end else begin
                            ls_rdata <= shifted[LINE_WIDTH-1 -: 32] >> rsh;
                            ls_done  <= 1'b1;
                        end
                    end
                end
                STORE:
                    if (cnt == n) begin
                        wr_q    <= 1'b0;
                        ls_done <= 1'b1;
                    end else begin
                        mem_a    <= st_addr;
                        mem_dout <= st_byte;
                        wr_q     <= !stall;
                        if (!stall) cnt <= cnt + 4'd1;
                    end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: table vectors, corner sequences and random traffic against a byte-array memory model.
module tb_mem_ctrl;
    localparam logic [31:0] IO_BASE = 32'h00030000;

    logic clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1;
    logic if_signal = 1'b0, ls_signal = 1'b0, ls_wr = 1'b0, io_buffer_full = 1'b0;
    logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
    logic [1:0] ls_len = '0;
    logic if_done, ls_done, mem_wr;
    logic [63:0] if_data;
    logic [31:0] ls_rdata, mem_a;
    logic [7:0] mem_dout, mem_din;

    logic bd_we = 1'b0;
    logic [15:0] bd_addr = '0;
    logic [7:0] bd_data = '0;
    logic [7:0] ram [0:65535];
    logic [7:0] model [0:65535];
    logic [39:0] wr_log [$];
    int checks = 0, errors = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } vec_t;
    vec_t tv [10];

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_signal(if_signal), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_signal(ls_signal), .ls_wr(ls_wr), .ls_len(ls_len), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    // synchronous-read RAM; IO addresses are not backed by storage
    always @(posedge clk_in) begin
        mem_din <= ram[mem_a[15:0]];
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (mem_wr && mem_a < IO_BASE) ram[mem_a[15:0]] <= mem_dout;
    end

    always @(negedge clk_in) if (mem_wr) wr_log.push_back({mem_a, mem_dout});

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        bd_addr = a; bd_data = d; bd_we = 1'b1; model[a] = d;
        @(posedge clk_in); #1;
        bd_we = 1'b0;
    endtask

    function automatic int nb(input logic [1:0] len);
        return len == 2'b00 ? 1 : len == 2'b01 ? 2 : 4;
    endfunction

    function automatic logic [31:0] mload(input logic [31:0] addr, input logic [1:0] len);
        logic [31:0] r = '0;
        for (int i = 0; i < nb(len); i++) r |= 32'(model[addr[15:0] + 16'(i)]) << (8 * i);
        return r;
    endfunction

    function automatic logic [63:0] mline(input logic [31:0] addr);
        logic [63:0] r = '0;
        for (int i = 0; i < 8; i++) r |= 64'(model[addr[15:0] + 16'(i)]) << (8 * i);
        return r;
    endfunction

    task automatic ls_req(input logic wr, input logic [1:0] len, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat);
        @(posedge clk_in); #1;
        ls_wr = wr; ls_len = len; ls_addr = addr; ls_wdata = wd; ls_signal = 1'b1;
        @(posedge clk_in); #1;
        lat = 0;
        while (!ls_done && lat < 100) begin @(posedge clk_in); #1; lat++; end
        ls_signal = 1'b0;
    endtask

    task automatic if_req(input logic [31:0] addr, output int lat);
        @(posedge clk_in); #1;
        if_addr = addr; if_signal = 1'b1;
        @(posedge clk_in); #1;
        lat = 0;
        while (!if_done && lat < 100) begin @(posedge clk_in); #1; lat++; end
        @(posedge clk_in); #1;
        chk("if_done_width", if_done, 1'b0);
        if_signal = 1'b0;
    endtask

    task automatic chk_writes(input string name, input int start, input logic [31:0] addr,
                              input logic [31:0] wd, input int n);
        chk({name, "_count"}, wr_log.size() - start, n);
        for (int i = 0; i < n; i++)
            if (start + i < wr_log.size())
                chk(name, wr_log[start + i], {addr + 32'(i), wd[8*i +: 8]});
    endtask

    task automatic watch(input int cyc, output int pulses);
        pulses = 0;
        repeat (cyc) begin @(posedge clk_in); #1; pulses += int'(if_done) + int'(ls_done); end
    endtask

    initial begin
        int lat, k, hi, start, pulses;
        logic early;
        logic [1:0] len;
        logic [31:0] addr, wd;
        tv = '{
            '{1'b0, 2'b10, 32'h100, 32'h0,        32'hEFBEADDE, 5},
            '{1'b0, 2'b01, 32'h100, 32'h0,        32'h0000ADDE, 3},
            '{1'b0, 2'b00, 32'h100, 32'h0,        32'h000000DE, 2},
            '{1'b1, 2'b10, 32'h200, 32'hA1B2C3D4, 32'h0,        4},
            '{1'b0, 2'b10, 32'h200, 32'h0,        32'hA1B2C3D4, 5},
            '{1'b0, 2'b11, 32'h100, 32'h0,        32'hEFBEADDE, 5},
            '{1'b1, 2'b01, 32'h300, 32'h12345678, 32'h0,        2},
            '{1'b0, 2'b10, 32'h300, 32'h0,        32'h00005678, 5},
            '{1'b1, 2'b00, 32'h301, 32'h0000009A, 32'h0,        1},
            '{1'b0, 2'b10, 32'h300, 32'h0,        32'h00009A78, 5}
        };
        for (int i = 0; i < 8; i++) poke(16'(i), 8'((i + 1) * 8'h11));
        poke(16'h100, 8'hDE); poke(16'h101, 8'hAD); poke(16'h102, 8'hBE); poke(16'h103, 8'hEF);
        for (int i = 0; i < 4; i++) poke(16'h300 + 16'(i), 8'h00);
        for (int i = 0; i < 256; i++) poke(16'h1000 + 16'(i), 8'($urandom));

        chk("reset_ctl", {if_done, ls_done, mem_wr, mem_dout, mem_a}, '0);
        chk("reset_if_data", if_data, '0);
        chk("reset_ls_rdata", ls_rdata, '0);
        #2 rst_in = 1'b1;
        @(posedge clk_in); #1;
        chk("idle_ctl", {if_done, ls_done, mem_wr, mem_a}, '0);

        if_req(32'h0, lat);
        chk("ifetch_lat", lat, 9);
        chk("ifetch_data", if_data, 64'h8877665544332211);
        watch(12, pulses);
        chk("ifetch_no_refire", pulses, 0);

        for (int i = 0; i < 10; i++) begin
            start = wr_log.size();
            ls_req(tv[i].wr, tv[i].len, tv[i].addr, tv[i].wdata, lat);
            chk($sformatf("tv%0d_lat", i), lat, tv[i].lat);
            if (tv[i].wr) chk_writes($sformatf("tv%0d_wr", i), start, tv[i].addr, tv[i].wdata, nb(tv[i].len));
            else chk($sformatf("tv%0d_rdata", i), ls_rdata, tv[i].rdata);
        end

        @(posedge clk_in); #1;
        io_buffer_full = 1'b1; ls_wr = 1'b1; ls_len = 2'b00; ls_addr = IO_BASE; ls_wdata = 32'h5A;
        ls_signal = 1'b1; start = wr_log.size(); hi = 0;
        repeat (3) begin @(posedge clk_in); #1; hi += int'(mem_wr); end
        chk("io_stall_wr", hi, 0);
        io_buffer_full = 1'b0;
        @(posedge clk_in); #1;
        chk("io_write", {mem_wr, ls_done, mem_a, mem_dout}, {1'b1, 1'b0, IO_BASE, 8'h5A});
        @(posedge clk_in); #1;
        chk("io_done", {ls_done, mem_wr}, 2'b10);
        ls_signal = 1'b0;
        chk("io_write_count", wr_log.size() - start, 1);

        @(posedge clk_in); #1;
        ls_wr = 1'b0; ls_len = 2'b10; ls_addr = 32'h100; if_addr = 32'h1000;
        ls_signal = 1'b1; if_signal = 1'b1; early = 1'b0;
        @(posedge clk_in); #1;
        lat = 0;
        while (!ls_done && lat < 100) begin early |= if_done; @(posedge clk_in); #1; lat++; end
        ls_signal = 1'b0;
        chk("race_ls_lat", lat, 5);
        chk("race_ls_rdata", ls_rdata, 32'hEFBEADDE);
        chk("race_if_first", early, 1'b0);
        k = 0;
        while (!if_done && k < 100) begin @(posedge clk_in); #1; k++; end
        chk("race_if_lat", k, 10);
        chk("race_if_data", if_data, mline(32'h1000));
        @(posedge clk_in); #1;
        if_signal = 1'b0;

        @(posedge clk_in); #1;
        ls_wr = 1'b1; ls_len = 2'b10; ls_addr = 32'h400; ls_wdata = 32'hCAFEF00D;
        ls_signal = 1'b1; start = wr_log.size();
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        lat = 1;
        rdy_in = 1'b0;
        #1 hi = int'(mem_wr);
        repeat (4) begin @(posedge clk_in); #1; lat++; hi += int'(mem_wr); end
        chk("rdy_hold_wr", hi, 0);
        rdy_in = 1'b1;
        while (!ls_done && lat < 100) begin @(posedge clk_in); #1; lat++; end
        ls_signal = 1'b0;
        chk("rdy_hold_lat", lat, 8);
        chk_writes("rdy_hold_seq", start, 32'h400, 32'hCAFEF00D, 4);
        for (int i = 0; i < 4; i++) model[16'h400 + 16'(i)] = 8'(32'hCAFEF00D >> (8 * i));

        @(posedge clk_in); #1;
        if_addr = 32'h0; if_signal = 1'b1;
        repeat (4) begin @(posedge clk_in); #1; end
        rst_in = 1'b0;
        #1;
        chk("abort_ctl", {if_done, ls_done, mem_wr, mem_dout, mem_a}, '0);
        chk("abort_if_data", if_data, '0);
        chk("abort_ls_rdata", ls_rdata, '0);
        if_signal = 1'b0;
        #3 rst_in = 1'b1;
        watch(12, pulses);
        chk("abort_no_done", pulses, 0);

        for (int t = 0; t < 40; t++) begin
            len = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: begin
                    addr = 32'h1000 + 32'(8 * $urandom_range(0, 31));
                    if_req(addr, lat);
                    chk($sformatf("rnd%0d_if_lat", t), lat, 9);
                    chk($sformatf("rnd%0d_if_data", t), if_data, mline(addr));
                end
                1: begin
                    addr = 32'h1000 + 32'($urandom_range(0, 16'hFC));
                    ls_req(1'b0, len, addr, 32'h0, lat);
                    chk($sformatf("rnd%0d_ld_lat", t), lat, nb(len) + 1);
                    chk($sformatf("rnd%0d_ld_data", t), ls_rdata, mload(addr, len));
                end
                default: begin
                    addr = 32'h1000 + 32'($urandom_range(0, 16'hFC));
                    wd = $urandom;
                    start = wr_log.size();
                    ls_req(1'b1, len, addr, wd, lat);
                    chk($sformatf("rnd%0d_st_lat", t), lat, nb(len));
                    chk_writes($sformatf("rnd%0d_st", t), start, addr, wd, nb(len));
                    for (int i = 0; i < nb(len); i++) model[addr[15:0] + 16'(i)] = wd[8*i +: 8];
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
